// File: rtl/coh_req_arbiter.sv
// Arbitrates CPU and snoop coherence requests onto a single MESIF engine issue slot and
// routes the engine result (or a synthesized error) back to whichever side was granted.
module coh_req_arbiter #(
  parameter int unsigned TAG_BITS   = 12,
  parameter int unsigned INDEX_BITS = 14,
  parameter int unsigned OPR_BITS   = 4,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [OPR_BITS-1:0]   cpu_opr,
  input  logic [TAG_BITS-1:0]   cpu_tag,
  input  logic [INDEX_BITS-1:0] cpu_index,

  input  logic                  snp_valid,
  output logic                  snp_ready,
  input  logic [OPR_BITS-1:0]   snp_opr,
  input  logic [TAG_BITS-1:0]   snp_tag,
  input  logic [INDEX_BITS-1:0] snp_index,

  output logic                  eng_valid,
  output logic [OPR_BITS-1:0]   eng_opr,
  output logic [TAG_BITS-1:0]   eng_tag,
  output logic [INDEX_BITS-1:0] eng_index,
  input  logic                  eng_done,
  input  logic [2:0]            eng_bus,
  input  logic [1:0]            eng_snoop,

  output logic                  cpu_rsp_valid,
  output logic [2:0]            cpu_rsp_bus,
  output logic                  snp_rsp_valid,
  output logic [1:0]            snp_rsp_snoop,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int unsigned WaitW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [StarveW-1:0] StarveTop = StarveW'(STARVE_MAX);
  localparam logic [WaitW-1:0]   WaitLast  = WaitW'(TIMEOUT - 1);
  localparam logic [2:0]         BusNop    = 3'd5;
  localparam logic [1:0]         SnpNohit  = 2'd2;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                  state_q;
  logic [StarveW-1:0]      starve_q;
  logic [WaitW-1:0]        wait_q;
  logic                    src_snp_q;
  logic [OPR_BITS-1:0]     opr_q;
  logic [TAG_BITS-1:0]     tag_q;
  logic [INDEX_BITS-1:0]   index_q;
  logic                    eng_valid_q;
  logic                    cpu_rsp_valid_q;
  logic                    snp_rsp_valid_q;
  logic                    rsp_err_q;
  logic [2:0]              rsp_bus_q;
  logic [1:0]              rsp_snoop_q;

  logic cpu_wins;
  logic grant_cpu;
  logic grant_snp;
  logic grant_any;
  logic grant_legal;

  function automatic logic cpu_opr_legal(input logic [OPR_BITS-1:0] opr);
    case (32'(opr))
      32'd0, 32'd1, 32'd2, 32'd8, 32'd9: cpu_opr_legal = 1'b1;
      default:                           cpu_opr_legal = 1'b0;
    endcase
  endfunction

  function automatic logic snp_opr_legal(input logic [OPR_BITS-1:0] opr);
    case (32'(opr))
      32'd3, 32'd4, 32'd5, 32'd6: snp_opr_legal = 1'b1;
      default:                    snp_opr_legal = 1'b0;
    endcase
  endfunction

  // Snoops win by default; a waiting CPU request overrides once it has been passed over
  // STARVE_MAX times in a row.
  always_comb begin
    cpu_wins  = cpu_valid && (starve_q == StarveTop);
    grant_snp = 1'b0;
    grant_cpu = 1'b0;
    if (state_q == StIdle) begin
      grant_snp = snp_valid && !cpu_wins;
      grant_cpu = cpu_valid && !grant_snp;
    end
    grant_any   = grant_cpu | grant_snp;
    grant_legal = grant_snp ? snp_opr_legal(snp_opr) : cpu_opr_legal(cpu_opr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      starve_q        <= '0;
      wait_q          <= '0;
      src_snp_q       <= 1'b0;
      opr_q           <= '0;
      tag_q           <= '0;
      index_q         <= '0;
      eng_valid_q     <= 1'b0;
      cpu_rsp_valid_q <= 1'b0;
      snp_rsp_valid_q <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_bus_q       <= '0;
      rsp_snoop_q     <= '0;
    end else begin
      eng_valid_q     <= 1'b0;
      cpu_rsp_valid_q <= 1'b0;
      snp_rsp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            src_snp_q <= grant_snp;
            opr_q     <= grant_snp ? snp_opr   : cpu_opr;
            tag_q     <= grant_snp ? snp_tag   : cpu_tag;
            index_q   <= grant_snp ? snp_index : cpu_index;
            if (grant_cpu) begin
              starve_q <= '0;
            end else if (cpu_valid && (starve_q != StarveTop)) begin
              starve_q <= starve_q + 1'b1;
            end
            if (grant_legal) begin
              state_q     <= StIssue;
              eng_valid_q <= 1'b1;
            end else begin
              // Illegal opcode: answer immediately without touching the engine.
              state_q         <= StResp;
              rsp_err_q       <= 1'b1;
              rsp_bus_q       <= BusNop;
              rsp_snoop_q     <= SnpNohit;
              cpu_rsp_valid_q <= grant_cpu;
              snp_rsp_valid_q <= grant_snp;
            end
          end
        end
        StIssue: begin
          state_q <= StWait;
          wait_q  <= '0;
        end
        StWait: begin
          if (eng_done) begin
            state_q         <= StResp;
            rsp_err_q       <= 1'b0;
            rsp_bus_q       <= eng_bus;
            rsp_snoop_q     <= eng_snoop;
            cpu_rsp_valid_q <= !src_snp_q;
            snp_rsp_valid_q <= src_snp_q;
          end else if (wait_q == WaitLast) begin
            state_q         <= StResp;
            rsp_err_q       <= 1'b1;
            rsp_bus_q       <= BusNop;
            rsp_snoop_q     <= SnpNohit;
            cpu_rsp_valid_q <= !src_snp_q;
            snp_rsp_valid_q <= src_snp_q;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Every output is forced low while reset is asserted, independent of register state.
  assign cpu_ready     = rst_n & grant_cpu;
  assign snp_ready     = rst_n & grant_snp;
  assign eng_valid     = rst_n & eng_valid_q;
  assign eng_opr       = rst_n ? opr_q   : '0;
  assign eng_tag       = rst_n ? tag_q   : '0;
  assign eng_index     = rst_n ? index_q : '0;
  assign cpu_rsp_valid = rst_n & cpu_rsp_valid_q;
  assign snp_rsp_valid = rst_n & snp_rsp_valid_q;
  assign cpu_rsp_bus   = rst_n ? rsp_bus_q   : '0;
  assign snp_rsp_snoop = rst_n ? rsp_snoop_q : '0;
  assign rsp_err       = rst_n & rsp_err_q;
  assign busy          = rst_n && (state_q != StIdle);

endmodule

// File: tb/tb_coh_req_arbiter.sv
// Scoreboard bench for coh_req_arbiter: drivers push expected responses at offer time and
// an independent negedge monitor checks grants, engine issues and responses as they appear.
module tb_coh_req_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_valid, cpu_ready, snp_valid, snp_ready;
  logic [3:0]  cpu_opr, snp_opr, eng_opr;
  logic [11:0] cpu_tag, snp_tag, eng_tag;
  logic [13:0] cpu_index, snp_index, eng_index;
  logic        eng_valid, eng_done;
  logic [2:0]  eng_bus, cpu_rsp_bus;
  logic [1:0]  eng_snoop, snp_rsp_snoop;
  logic        cpu_rsp_valid, snp_rsp_valid, rsp_err, busy;

  always #5 clk = ~clk;

  coh_req_arbiter #(
    .TAG_BITS(12), .INDEX_BITS(14), .OPR_BITS(4), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_opr(cpu_opr), .cpu_tag(cpu_tag),
    .cpu_index(cpu_index),
    .snp_valid(snp_valid), .snp_ready(snp_ready), .snp_opr(snp_opr), .snp_tag(snp_tag),
    .snp_index(snp_index),
    .eng_valid(eng_valid), .eng_opr(eng_opr), .eng_tag(eng_tag), .eng_index(eng_index),
    .eng_done(eng_done), .eng_bus(eng_bus), .eng_snoop(eng_snoop),
    .cpu_rsp_valid(cpu_rsp_valid), .cpu_rsp_bus(cpu_rsp_bus),
    .snp_rsp_valid(snp_rsp_valid), .snp_rsp_snoop(snp_rsp_snoop),
    .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct { logic [2:0] bus; logic [1:0] snoop; logic err; int lat; } rsp_t;
  typedef struct { logic [3:0] opr; logic [11:0] tag; logic [13:0] idx; int cyc; } iss_t;

  rsp_t cpu_q[$];
  rsp_t snp_q[$];
  iss_t iss_q[$];
  bit   gseq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   cpu_gcyc = 0;
  int   snp_gcyc = 0;
  int   m_starve = 0;

  // Engine behaviour: either forced by a directed test or derived from the request tag.
  bit         force_en = 1'b0;
  int         force_d = 0;
  logic [2:0] force_bus = 3'd0;
  logic [1:0] force_snoop = 2'd0;

  logic [3:0] cpu_ops [5] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
  logic [3:0] snp_ops [4] = '{4'd3, 4'd4, 4'd5, 4'd6};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit cpu_legal(input logic [3:0] o);
    return o inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
  endfunction

  function automatic bit snp_legal(input logic [3:0] o);
    return o inside {4'd3, 4'd4, 4'd5, 4'd6};
  endfunction

  // Cycles from eng_valid to the eng_done cycle; 0 means the engine never answers.
  function automatic int plan_d(input logic [11:0] tag);
    int code;
    if (force_en) return force_d;
    code = int'(tag[4:0]);
    if (code >= 30) return 0;
    return (code % 16) + 1;
  endfunction

  function automatic logic [2:0] plan_bus(input logic [11:0] tag);
    if (force_en) return force_bus;
    return 3'((int'(tag[7:5]) % 5) + 1);
  endfunction

  function automatic logic [1:0] plan_snoop(input logic [11:0] tag);
    if (force_en) return force_snoop;
    return 2'(int'(tag[9:8]) % 3);
  endfunction

  // Response and accept-to-response latency predicted from the request alone.
  function automatic rsp_t model_rsp(input bit is_snp, input logic [3:0] o,
                                     input logic [11:0] tag);
    rsp_t r;
    int   d;
    r.bus = 3'd5; r.snoop = 2'd2; r.err = 1'b1; r.lat = 1;
    if (is_snp ? snp_legal(o) : cpu_legal(o)) begin
      d = plan_d(tag);
      if (d == 0) begin
        r.lat = 2 + TIMEOUT;
      end else begin
        r.bus = plan_bus(tag); r.snoop = plan_snoop(tag); r.err = 1'b0; r.lat = d + 2;
      end
    end
    return r;
  endfunction

  task automatic cpu_send(input logic [3:0] o, input logic [11:0] t, input logic [13:0] i);
    bit got = 1'b0;
    cpu_q.push_back(model_rsp(1'b0, o, t));
    cpu_opr = o; cpu_tag = t; cpu_index = i; cpu_valid = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = cpu_ready;
    end
    if (!got) begin
      chk("cpu_accept_timeout", 64'd0, 64'd1);
      void'(cpu_q.pop_back());
    end
    @(posedge clk);
    #1 cpu_valid = 1'b0;
  endtask

  task automatic snp_send(input logic [3:0] o, input logic [11:0] t, input logic [13:0] i);
    bit got = 1'b0;
    snp_q.push_back(model_rsp(1'b1, o, t));
    snp_opr = o; snp_tag = t; snp_index = i; snp_valid = 1'b1;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      got = snp_ready;
    end
    if (!got) begin
      chk("snp_accept_timeout", 64'd0, 64'd1);
      void'(snp_q.pop_back());
    end
    @(posedge clk);
    #1 snp_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && (cpu_q.size() + snp_q.size() + iss_q.size()) != 0; k++)
      @(posedge clk);
    chk("drain_timeout", 64'(cpu_q.size() + snp_q.size() + iss_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Engine responder.
  initial begin
    int         d;
    logic [2:0] b;
    logic [1:0] s;
    eng_done = 1'b0; eng_bus = 3'd0; eng_snoop = 2'd0;
    forever begin
      @(negedge clk);
      if (rst_n && eng_valid) begin
        d = plan_d(eng_tag); b = plan_bus(eng_tag); s = plan_snoop(eng_tag);
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1 eng_done = 1'b1; eng_bus = b; eng_snoop = s;
          @(posedge clk);
          #1 eng_done = 1'b0; eng_bus = 3'd0; eng_snoop = 2'd0;
        end
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    rsp_t r;
    iss_t e;
    logic exp_snp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cpu_ready || snp_ready) begin
          exp_snp = snp_valid && !(cpu_valid && m_starve == STARVE_MAX);
          chk("grant_onehot", 64'(cpu_ready & snp_ready), 64'd0);
          chk("grant_src", 64'(snp_ready), 64'(exp_snp));
          if (snp_ready) begin
            gseq.push_back(1'b1);
            snp_gcyc = cyc;
            if (cpu_valid && m_starve < STARVE_MAX) m_starve++;
            if (snp_legal(snp_opr)) begin
              e.opr = snp_opr; e.tag = snp_tag; e.idx = snp_index; e.cyc = cyc + 1;
              iss_q.push_back(e);
            end
          end else begin
            gseq.push_back(1'b0);
            cpu_gcyc = cyc;
            m_starve = 0;
            if (cpu_legal(cpu_opr)) begin
              e.opr = cpu_opr; e.tag = cpu_tag; e.idx = cpu_index; e.cyc = cyc + 1;
              iss_q.push_back(e);
            end
          end
        end
        if (eng_valid) begin
          if (iss_q.size() == 0) chk("eng_unexpected", 64'd1, 64'd0);
          else begin
            e = iss_q.pop_front();
            chk("eng_fields", 64'({eng_opr, eng_tag, eng_index}), 64'({e.opr, e.tag, e.idx}));
            chk("eng_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
        if (cpu_rsp_valid || snp_rsp_valid)
          chk("rsp_both", 64'(cpu_rsp_valid & snp_rsp_valid), 64'd0);
        if (cpu_rsp_valid) begin
          if (cpu_q.size() == 0) chk("cpu_rsp_unexpected", 64'd1, 64'd0);
          else begin
            r = cpu_q.pop_front();
            chk("cpu_rsp_bus", 64'(cpu_rsp_bus), 64'(r.bus));
            chk("cpu_rsp_err", 64'(rsp_err), 64'(r.err));
            chk("cpu_rsp_lat", 64'(cyc - cpu_gcyc), 64'(r.lat));
          end
        end
        if (snp_rsp_valid) begin
          if (snp_q.size() == 0) chk("snp_rsp_unexpected", 64'd1, 64'd0);
          else begin
            r = snp_q.pop_front();
            chk("snp_rsp_snoop", 64'(snp_rsp_snoop), 64'(r.snoop));
            chk("snp_rsp_err", 64'(rsp_err), 64'(r.err));
            chk("snp_rsp_lat", 64'(cyc - snp_gcyc), 64'(r.lat));
          end
        end
      end
    end
  end

  // Directed scenarios, then randomized traffic.
  initial begin
    logic [5:0] order;
    cpu_valid = 1'b1; snp_valid = 1'b1;
    cpu_opr = 4'd1; cpu_tag = 12'h0; cpu_index = 14'h0;
    snp_opr = 4'd4; snp_tag = 12'h0; snp_index = 14'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 64'({cpu_ready, snp_ready, eng_valid, eng_opr, eng_tag, eng_index,
        cpu_rsp_valid, cpu_rsp_bus, snp_rsp_valid, snp_rsp_snoop, rsp_err, busy}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1; cpu_valid = 1'b0; snp_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 64'({busy, cpu_ready, snp_ready}), 64'd0);
    @(posedge clk);
    #1;

    // CPU alone, engine answers 3 cycles after issue with RFO.
    force_en = 1'b1; force_d = 3; force_bus = 3'd4; force_snoop = 2'd0;
    cpu_send(4'd1, 12'h003, 14'h0010);
    wait_idle();

    // Both sides held: four snoop grants, then the starved CPU, then snoop again.
    force_d = 1; force_bus = 3'd2; force_snoop = 2'd1;
    gseq.delete();
    fork
      begin
        for (int n = 0; n < 7; n++) snp_send(snp_ops[n % 4], 12'(n + 12'h100), 14'(n));
      end
      begin
        for (int n = 0; n < 3; n++) cpu_send(cpu_ops[n], 12'(n + 12'h200), 14'(n + 14'h40));
      end
    join
    wait_idle();
    chk("starve_seq_len", 64'(gseq.size() >= 6), 64'd1);
    order = 6'd0;
    for (int k = 0; k < 6 && k < gseq.size(); k++) order[5 - k] = gseq[k];
    chk("starve_order", 64'(order), 64'(6'b111101));

    // Snoop with a silent engine times out.
    force_d = 0;
    snp_send(4'd4, 12'h055, 14'h0123);
    wait_idle();

    // Illegal CPU opcode: immediate error response, no engine issue.
    cpu_send(4'd7, 12'h0AA, 14'h0321);
    wait_idle();

    // Done in the last WAIT cycle beats the timeout.
    force_d = TIMEOUT; force_bus = 3'd3; force_snoop = 2'd1;
    snp_send(4'd5, 12'h077, 14'h0777);
    wait_idle();

    // Reset during WAIT drops the request; the late eng_done must be ignored.
    force_d = 8; force_bus = 3'd1; force_snoop = 2'd0;
    cpu_send(4'd0, 12'h0F0, 14'h00F0);
    gap(3);
    rst_n = 1'b0;
    cpu_q.delete(); iss_q.delete(); m_starve = 0;
    @(negedge clk);
    chk("midreset_outputs", 64'({cpu_ready, snp_ready, eng_valid, eng_opr, eng_tag, eng_index,
        cpu_rsp_valid, cpu_rsp_bus, snp_rsp_valid, snp_rsp_snoop, rsp_err, busy}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    gap(12);
    @(negedge clk);
    chk("busy_after_reset", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    force_d = 2; force_bus = 3'd2; force_snoop = 2'd2;
    cpu_send(4'd9, 12'h0E1, 14'h0E1);
    wait_idle();

    // Random traffic on both ports, engine behaviour keyed off the tag.
    force_en = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          gap($urandom_range(0, 3));
          cpu_send(($urandom_range(0, 9) < 7) ? cpu_ops[$urandom_range(0, 4)] : 4'($urandom),
                   12'($urandom), 14'($urandom));
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          gap($urandom_range(0, 3));
          snp_send(($urandom_range(0, 9) < 7) ? snp_ops[$urandom_range(0, 3)] : 4'($urandom),
                   12'($urandom), 14'($urandom));
        end
      end
    join
    wait_idle();
    chk("queues_drained", 64'(cpu_q.size() + snp_q.size() + iss_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/coh_req_arbiter.md
COH_REQ_ARBITER -- requirements
Module: coh_req_arbiter

Interface
REQ-001 Parameters SHALL be: TAG_BITS, default 12, tag width; INDEX_BITS, default 14, index width; OPR_BITS, default 4, opcode width; STARVE_MAX, default 4, consecutive snoop grants allowed while a CPU request waits; TIMEOUT, default 16, WAIT cycles before abort.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low. Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- cpu_valid / cpu_ready  in / out  1  CPU request handshake
- cpu_opr, cpu_tag, cpu_index  in  OPR_BITS / TAG_BITS / INDEX_BITS  CPU request
- snp_valid / snp_ready  in / out  1  snoop request handshake
- snp_opr, snp_tag, snp_index  in  OPR_BITS / TAG_BITS / INDEX_BITS  snoop request
- eng_valid  out  1  one-cycle issue pulse to the MESIF engine
- eng_opr, eng_tag, eng_index  out  OPR_BITS / TAG_BITS / INDEX_BITS  issued request
- eng_done  in  1  engine completion pulse
- eng_bus  in  3  engine bus op (1 READ, 2 WRITE, 3 INVALIDATE, 4 RFO, 5 NOP)
- eng_snoop  in  2  engine snoop result (0 HIT, 1 HITM, 2 NOHIT)
- cpu_rsp_valid  out  1  CPU response pulse
- cpu_rsp_bus  out  3  bus op returned to the CPU side
- snp_rsp_valid  out  1  snoop response pulse
- snp_rsp_snoop  out  2  snoop result returned to the snoop side
- rsp_err  out  1  response error flag, valid with either rsp_valid
- busy  out  1  high in any state other than IDLE

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, RESP.
REQ-004 In IDLE, with any valid high, the block SHALL grant exactly one source.
- cpu_ready/snp_ready are combinational: high only in IDLE for the granted source.
- The grant cycle is the accept cycle; opcode, tag, index and source are captured at that edge.
REQ-005 Priority SHALL be: snoop wins, unless cpu_valid=1 and starve_cnt==STARVE_MAX, in which case CPU wins.
REQ-006 starve_cnt SHALL increment on a snoop grant while cpu_valid=1, saturate at STARVE_MAX, and clear on any CPU grant.
REQ-007 Legal opcodes SHALL be: CPU port {0,1,2,8,9}; snoop port {3,4,5,6}.
REQ-008 A legal grant SHALL go IDLE->ISSUE. An illegal opcode SHALL be accepted and go IDLE->RESP with rsp_err=1, cpu_rsp_bus=5 / snp_rsp_snoop=2, and no engine issue.
REQ-009 ISSUE SHALL drive eng_valid=1 with the captured fields for exactly one cycle, then enter WAIT with wait_cnt=0.
REQ-010 In WAIT, eng_done=1 SHALL capture eng_bus/eng_snoop, set rsp_err=0, and go to RESP.
- Otherwise wait_cnt increments.
- When wait_cnt reaches TIMEOUT-1 with no done: go to RESP with rsp_err=1, bus=5, snoop=2.
- If done and timeout coincide, done wins.
REQ-011 RESP SHALL pulse cpu_rsp_valid or snp_rsp_valid (captured source only) for one cycle, then return to IDLE.
- No new grant is made in RESP.
- Response fields hold until the next response.
REQ-012 Latency: accept at T, eng_valid at T+1, earliest eng_done at T+2, rsp_valid at done+1; illegal-opcode response at T+1.
REQ-013 eng_done outside WAIT SHALL be ignored.
REQ-014 Request inputs SHALL be ignored outside IDLE; requesters hold valid until ready.

Reset
REQ-015 When rst_n=0 at a clock edge, the block SHALL, regardless of state, enter IDLE and clear starve_cnt, wait_cnt and captured fields to 0.
REQ-016 During reset, all outputs SHALL be 0 (ready, eng_valid, rsp_valid, rsp_err, busy, eng fields, cpu_rsp_bus, snp_rsp_snoop).
REQ-017 A request in flight at reset SHALL be dropped with no response; a late eng_done after reset SHALL be ignored.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- CPU opr=1, tag=0x3, index=0x10 alone; eng_done 3 cycles after eng_valid with eng_bus=4 -> cpu_rsp_valid one cycle later, cpu_rsp_bus=4, rsp_err=0.
- cpu_valid and snp_valid both held continuously; engine done after 1 cycle -> 4 snoop grants, then 1 CPU grant, then snoop again; starve_cnt 4->0.
- Snoop opr=4, engine never responds -> snp_rsp_valid 16 cycles after entering WAIT, rsp_err=1, snp_rsp_snoop=2.
- CPU opr=7 -> accepted, no eng_valid, cpu_rsp_valid at T+1, rsp_err=1, cpu_rsp_bus=5.
- rst_n=0 for one cycle during WAIT, then eng_done=1 -> no response, busy=0, IDLE.
- eng_done asserted in the same cycle wait_cnt reaches 15 -> rsp_err=0 and engine result returned.
